// File: rtl/note_sequencer_if.sv
// Handshake/bus bundle for the note sequencer: control pulses, pattern load and lane outputs.
interface note_sequencer_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DEPTH    = 100,
  parameter int unsigned VISIBLE  = 26,
  parameter int unsigned IDX_W    = 7,
  parameter int unsigned CH_W     = 2
);
  logic                         tick;
  logic                         start;
  logic                         stop;
  logic                         loop_mode;
  logic                         load_en;
  logic [CH_W-1:0]              load_chan;
  logic [DEPTH-1:0]             load_data;
  logic [CHANNELS-1:0]          hit_ack;
  logic [CHANNELS*VISIBLE-1:0]  window;
  logic [CHANNELS-1:0]          head;
  logic [IDX_W-1:0]             step;
  logic                         running;
  logic                         done;
  logic                         wrap;
  logic                         load_err;

  modport master (
    output tick, start, stop, loop_mode, load_en, load_chan, load_data, hit_ack,
    input  window, head, step, running, done, wrap, load_err
  );

  modport slave (
    input  tick, start, stop, loop_mode, load_en, load_chan, load_data, hit_ack,
    output window, head, step, running, done, wrap, load_err
  );
endinterface

// File: rtl/note_sequencer.sv
// Multi-lane note pattern store and scroller: rotates every lane one step per accepted tick,
// exposes a per-lane visible window and an unconsumed head bit for hit judging.
module note_sequencer #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DEPTH    = 100,
  parameter int unsigned VISIBLE  = 26,
  parameter int unsigned IDX_W    = 7,
  parameter int unsigned CH_W     = 2
) (
  input logic              clk,
  input logic              resetn,
  note_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    step_q, step_d;
  logic                mode_q, mode_d;
  logic [DEPTH-1:0]    pat_q [CHANNELS];
  logic [DEPTH-1:0]    pat_d [CHANNELS];
  logic [CHANNELS-1:0] cons_q, cons_d;
  logic                wrap_q, wrap_d;
  logic                load_err_q, load_err_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                tick_ok;
  logic                load_ok;

  logic [CHANNELS*VISIBLE-1:0] win;
  logic [CHANNELS-1:0]         head;

  // Next-state: FSM, step counter, lane rotation, hit consumption and loads.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    mode_d     = mode_q;
    pat_d      = pat_q;
    cons_d     = cons_q | bus.hit_ack;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    tick_ok    = (state_q == StRun) && bus.tick;
    load_ok    = (state_q != StRun) && (step_q == '0) &&
                 (int'(bus.load_chan) < int'(CHANNELS));

    if (tick_ok) begin
      // A tick always exposes a fresh, unconsumed head, even if a hit arrives alongside it.
      cons_d = '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        pat_d[c] = {pat_q[c][DEPTH-2:0], pat_q[c][DEPTH-1]};
      end
      if (step_q == IDX_W'(DEPTH - 1)) begin
        step_d = '0;
        wrap_d = 1'b1;
        if (!mode_q) state_d = StDone;
      end else begin
        step_d = step_q + IDX_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.stop) begin
          state_d = StRun;
          mode_d  = bus.loop_mode;
        end
      end
      StRun: begin
        if (bus.stop) state_d = StIdle;
      end
      StDone: begin
        if (bus.start && !bus.stop) begin
          state_d = StRun;
          mode_d  = bus.loop_mode;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.load_en) begin
      if (load_ok) begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
          if (int'(bus.load_chan) == c) begin
            pat_d[c]  = bus.load_data;
            cons_d[c] = 1'b0;
          end
        end
      end else begin
        load_err_d = 1'b1;
      end
    end

    running_d = (state_d == StRun);
    done_d    = (state_d == StDone);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      step_q     <= '0;
      mode_q     <= 1'b0;
      cons_q     <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      for (int c = 0; c < int'(CHANNELS); c++) pat_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      mode_q     <= mode_d;
      cons_q     <= cons_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
      running_q  <= running_d;
      done_q     <= done_d;
      for (int c = 0; c < int'(CHANNELS); c++) pat_q[c] <= pat_d[c];
    end
  end

  // Window decode; one-shot hides notes that would wrap in from the start of the song.
  always_comb begin
    win  = '0;
    head = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      for (int j = 0; j < int'(VISIBLE); j++) begin
        win[c*VISIBLE+j] = pat_q[c][DEPTH-VISIBLE+j];
        if (!mode_q && (int'(step_q) + int'(VISIBLE) - 1 - j >= int'(DEPTH))) begin
          win[c*VISIBLE+j] = 1'b0;
        end
      end
      head[c] = win[c*VISIBLE+VISIBLE-1] & ~cons_q[c];
    end
  end

  assign bus.window   = win;
  assign bus.head     = head;
  assign bus.step     = step_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Parametrised multi-lane note pattern store and scroller for the rhythm game. It holds one DEPTH-step pattern per lane and advances all lanes one step per tick. It exposes a VISIBLE-wide window per lane for the square animator, plus a per-lane head bit for player hit judging. It adds parallel per-lane loading, loop/one-shot play, end-of-song masking, per-head hit consumption and run/stop control.

Parameters:
CHANNELS, 3, number of note lanes (red/yellow/blue = lanes 2/1/0)
DEPTH, 100, pattern length in steps per lane (>= VISIBLE)
VISIBLE, 26, window width per lane
IDX_W, 7, step counter width, must satisfy 2**IDX_W > DEPTH
CH_W, 2, lane select width, must satisfy 2**CH_W >= CHANNELS

Ports:
clk  in  1  system clock (CLOCK_50 domain)
resetn  in  1  asynchronous active-low reset
tick  in  1  one-cycle step enable from song-rate divider
start  in  1  pulse: begin/resume play
stop  in  1  pulse: halt play, position kept
loop_mode  in  1  1 = loop forever, 0 = one-shot; latched on start
load_en  in  1  pulse: load pattern for one lane
load_chan  in  CH_W  lane index for load
load_data  in  DEPTH  pattern; bit DEPTH-1 = step 0 (first note to reach head)
hit_ack  in  CHANNELS  pulse per lane: current head note consumed
window  out  CHANNELS*VISIBLE  lane c at [c*VISIBLE +: VISIBLE]; bit VISIBLE-1 = head
head  out  CHANNELS  per-lane head note, unconsumed
step  out  IDX_W  current song position 0..DEPTH-1
running  out  1  high in RUN
done  out  1  high in DONE
wrap  out  1  one-cycle pulse at end of pattern
load_err  out  1  one-cycle pulse on rejected load

Behaviour:
- Reset (async, resetn=0): all pattern regs 0, consumed mask 0, step 0, mode 0, state IDLE; all outputs 0.
- Storage: one DEPTH-bit register per lane. On an accepted tick each lane rotates left by 1; bit DEPTH-1 re-enters at bit 0. After DEPTH ticks the pattern is restored exactly.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start -> RUN, latching loop_mode.
  - RUN: stop -> IDLE. tick advances the position.
  - DONE: start -> RUN, relatching the mode. Step is 0 here.
  - If start and stop arrive together, stop wins: no transition from IDLE; RUN -> IDLE.
- Tick is honoured only in RUN; in other states it is ignored.
  - Accepted tick with step<DEPTH-1: step+1.
  - Accepted tick with step==DEPTH-1: step -> 0 and wrap pulses next cycle.
    - Loop mode: stays in RUN.
    - One-shot: goes to DONE.
- Window bit j of lane c = reg_c[DEPTH-VISIBLE+j], which is note index step+(VISIBLE-1-j).
  - In one-shot mode, a bit is forced to 0 when step+(VISIBLE-1-j) >= DEPTH, so no wrapped-in notes appear.
  - In loop mode there is no masking.
- Hit consumption:
  - head[c] = window head bit AND NOT consumed[c].
  - hit_ack[c] sets consumed[c]. All consumed bits clear on an accepted tick.
  - If tick and hit_ack arrive in the same cycle, the tick wins: the new head is unconsumed.
  - Consumed bits do not alter the pattern registers, so loops replay intact.
- Load:
  - Accepted only when state != RUN and step==0 and load_chan < CHANNELS.
  - Lane load_chan <= load_data on the next edge, and consumed[load_chan] clears.
  - Otherwise the load is ignored and load_err pulses for one cycle.
  - If load and start arrive together in IDLE, both take effect: the pattern is loaded and the state enters RUN.
- stop mid-song keeps position; a later start resumes at the same step. Loads stay rejected until the pattern completes (DONE) or reset.
- All outputs are registered or decoded from registers. Latency: tick/hit/load to output change = 1 clk.

Test Plan:
- Reset, load lane0 = {25{4'b1010}}, start with loop_mode=0, 3 ticks -> step=3. window lane0 = original bits [DEPTH-VISIBLE-3 +: VISIBLE]. running=1.
- One-shot, DEPTH=100, VISIBLE=26, step driven to 80 -> window lane bits j<=5 read 0 regardless of pattern. After 100 ticks total: wrap pulse, done=1, step=0, registers equal the loaded pattern.
- Loop mode, 200 ticks -> wrap pulses exactly at ticks 100 and 200. running stays 1. The window at step 0 equals the loaded pattern top bits.
- Head=1 on lane2, hit_ack[2] -> head[2]=0 next cycle, window unchanged. Next tick -> consumed cleared. Tick and hit_ack in the same cycle -> the new head is shown unmasked.
- Run, stop at step 40, load_en -> load_err pulse, lane unchanged. Start -> resumes at step 40. load_chan=3 with CHANNELS=3 -> load_err.
- Assert resetn low mid-RUN at step 57 -> immediately state IDLE, step=0, window=0, all flags 0, no wrap pulse.
